// File: rtl/cim_inst_queue.sv
// -----------------------------------------------------------------------------
// cim_inst_queue
//
// Purpose:
//   Small instruction FIFO that sits between the CIM instruction source and
//   the rw_control stage. The FIFO buffers packed {op, s1, s2, d1} words. The
//   head entry is split into its fields combinationally. Illegal opcodes and
//   out-of-range array addresses are flagged on the head entry. Errored
//   entries are still delivered. Each errored pop is counted in a saturating
//   16-bit counter.
//
// Optional feature (macro CIM_INST_RANGE_CHECK_EN):
//   Defined   : out_err and err_count are live; err_clr clears err_count.
//   Undefined : no comparators and no counter are built. out_err and
//               err_count read as zero, and err_clr is ignored.
//   Queueing and the field split are the same in both builds.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   in_valid    in   instruction present
//   in_ready    out  queue can accept (registered-state only)
//   in_inst     in   {op, s1, s2, d1}, op in MSBs
//   out_valid   out  head entry available
//   out_ready   in   consumer takes head
//   out_op      out  head opcode
//   out_s1/s2/d1 out head address fields
//   out_err     out  bit0 illegal opcode, bit1 address >= CIM_DEPTH
//   fifo_count  out  occupied entries
//   err_clr     in   clear err_count (wins over a same-cycle increment)
//   err_count   out  errored pops, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module cim_inst_queue #(
  parameter int OP_BITS    = 8,
  parameter int ADDR_BITS  = 8,
  parameter int CIM_DEPTH  = 256,
  parameter int NUM_OPS    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [OP_BITS+3*ADDR_BITS-1:0]   in_inst,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OP_BITS-1:0]               out_op,
  output logic [ADDR_BITS-1:0]             out_s1,
  output logic [ADDR_BITS-1:0]             out_s2,
  output logic [ADDR_BITS-1:0]             out_d1,
  output logic [1:0]                       out_err,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  input  logic                             err_clr,
  output logic [15:0]                      err_count
);

  localparam int INST_BITS = OP_BITS + 3 * ADDR_BITS;
  localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS  = PTR_BITS + 1;

  logic [INST_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr_r;
  logic [PTR_BITS-1:0]  rd_ptr_r;
  logic [CNT_BITS-1:0]  count_r;
  logic [CNT_BITS-1:0]  count_next_s;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 push_s;
  logic                 pop_s;
  logic [INST_BITS-1:0] head_s;

  // Handshakes use only registered flags, so in_ready never depends on out_ready
  // and a full queue cannot accept a push in the same cycle as a pop.
  assign push_s = in_valid && in_ready_r;
  assign pop_s  = out_valid_r && out_ready;

  // Next occupancy: +1 on push only, -1 on pop only, hold otherwise
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_BITS'(1);
      2'b01:   count_next_s = count_r - CNT_BITS'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy and the registered ready/valid flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_BITS{1'b0}};
      rd_ptr_r    <= {PTR_BITS{1'b0}};
      count_r     <= {CNT_BITS{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      // Pointers are exactly log2(FIFO_DEPTH) bits wide, so the increment wraps on its own.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_BITS'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
      end
      count_r     <= count_next_s;
      in_ready_r  <= (count_next_s < CNT_BITS'(FIFO_DEPTH));
      out_valid_r <= (count_next_s != {CNT_BITS{1'b0}});
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_inst;
    end
  end

  assign head_s = mem_r[rd_ptr_r];

  // The head word is split into fields without a register stage.
  assign out_op = head_s[INST_BITS-1 -: OP_BITS];
  assign out_s1 = head_s[3*ADDR_BITS-1 -: ADDR_BITS];
  assign out_s2 = head_s[2*ADDR_BITS-1 -: ADDR_BITS];
  assign out_d1 = head_s[ADDR_BITS-1:0];

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign fifo_count = count_r;

`ifdef CIM_INST_RANGE_CHECK_EN
  // Common comparison width: wide enough for any field and for either limit.
  localparam int MAX_FIELD = (OP_BITS > ADDR_BITS) ? OP_BITS : ADDR_BITS;
  localparam int CMP_W     = ((MAX_FIELD > 32) ? MAX_FIELD : 32) + 1;
  localparam logic [CMP_W-1:0] OP_LIMIT  = CMP_W'(NUM_OPS);
  localparam logic [CMP_W-1:0] ROW_LIMIT = CMP_W'(CIM_DEPTH);

  logic [1:0]  err_flags_s;
  logic [15:0] err_count_r;

  // True when an opcode is outside 0..NUM_OPS-1 (unsigned, zero-extended)
  function automatic logic op_illegal(input logic [OP_BITS-1:0] op);
    return (CMP_W'(op) >= OP_LIMIT);
  endfunction

  // True when an array address is outside 0..CIM_DEPTH-1 (unsigned, zero-extended)
  function automatic logic addr_oob(input logic [ADDR_BITS-1:0] addr);
    return (CMP_W'(addr) >= ROW_LIMIT);
  endfunction

  // Error flags on the head entry; forced low while the queue is empty
  always_comb begin
    err_flags_s = 2'b00;
    if (out_valid_r) begin
      err_flags_s[0] = op_illegal(out_op);
      err_flags_s[1] = addr_oob(out_s1) || addr_oob(out_s2) || addr_oob(out_d1);
    end else begin
      err_flags_s = 2'b00;
    end
  end

  // Saturating count of errored pops; a clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_r <= 16'h0000;
    end else if (err_clr) begin
      err_count_r <= 16'h0000;
    end else if (pop_s && (err_flags_s != 2'b00) && (err_count_r != 16'hFFFF)) begin
      err_count_r <= err_count_r + 16'h0001;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign out_err   = err_flags_s;
  assign err_count = err_count_r;
`else
  // This build has no range checking. err_clr and the range limits have nothing
  // to drive, so they are gathered into one sink signal.
  logic unused_cfg_s;
  assign unused_cfg_s = ^{err_clr, 32'(NUM_OPS), 32'(CIM_DEPTH)};

  assign out_err   = 2'b00;
  assign err_count = 16'h0000;
`endif

endmodule
